// File: rtl/freq_limit_monitor.sv
// freq_limit_monitor
// Watches each published frequency count against runtime low/high limits and
// raises confirmed, hysteretic, latched under/over-frequency alarms. It also
// keeps min/max/sample-count statistics on the raw samples.
// Optional build macro: FREQ_AVG_EN. When it is defined, the compared value is
// the average of the last four raw samples, which adds one cycle of latency.
module freq_limit_monitor #(
    parameter int WIDTH   = 32,
    parameter int CONFIRM = 3,
    parameter int SCNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [WIDTH-1:0]  i_frequency_count,
    input  logic              i_count_valid,
    input  logic [WIDTH-1:0]  i_low_limit,
    input  logic [WIDTH-1:0]  i_high_limit,
    input  logic [WIDTH-1:0]  i_hyst,
    output logic              o_alarm_low,
    output logic              o_alarm_high,
    output logic              o_in_range,
    output logic              o_config_err,
    output logic [WIDTH-1:0]  o_min_count,
    output logic [WIDTH-1:0]  o_max_count,
    output logic [SCNT_W-1:0] o_sample_count
);

    typedef enum logic [2:0] {
        NORMAL,
        PEND_LO,
        PEND_HI,
        ALARM_LO,
        ALARM_HI
    } state_t;

    localparam int         CW        = 4;
    localparam logic [CW-1:0] CONFIRM_C = CW'(CONFIRM);
    // A single violation confirms the alarm, so the pending states are skipped.
    localparam bit         DIRECT    = (CONFIRM <= 1);

    state_t              r_state, w_nextState;
    logic [CW-1:0]       r_cnt, w_nextCnt;
    logic                r_inRange, w_nextInRange;
    logic                r_cfgErr, w_nextCfgErr;
    logic [WIDTH-1:0]    r_min, r_max;
    logic [SCNT_W-1:0]   r_sampleCnt;

    // Compare-stage inputs: the value to classify and the limits that go with it.
    logic                w_cmpValid;
    logic                w_cmpEnable;
    logic [WIDTH-1:0]    w_cmpValue;
    logic [WIDTH-1:0]    w_cmpLow;
    logic [WIDTH-1:0]    w_cmpHigh;
    logic [WIDTH-1:0]    w_cmpHyst;

    wire                 w_accept = i_count_valid && !i_reset;

`ifdef FREQ_AVG_EN
    logic [WIDTH-1:0]    r_hist0, r_hist1, r_hist2;
    logic [1:0]          r_histCnt;
    logic                r_avgValid;
    logic                r_avgReady;
    logic [WIDTH-1:0]    r_avgValue;
    logic [WIDTH-1:0]    r_avgLow, r_avgHigh, r_avgHyst;
    logic [WIDTH+1:0]    w_sum;

    assign w_sum = {2'b00, i_frequency_count} + {2'b00, r_hist0}
                 + {2'b00, r_hist1} + {2'b00, r_hist2};

    // Averaging stage: keeps the last three raw samples and registers the mean with its limits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hist0    <= '0;
            r_hist1    <= '0;
            r_hist2    <= '0;
            r_histCnt  <= '0;
            r_avgValid <= 1'b0;
            r_avgReady <= 1'b0;
            r_avgValue <= '0;
            r_avgLow   <= '0;
            r_avgHigh  <= '0;
            r_avgHyst  <= '0;
        end else begin
            r_avgValid <= i_count_valid;
            if (i_count_valid) begin
                r_hist0    <= i_frequency_count;
                r_hist1    <= r_hist0;
                r_hist2    <= r_hist1;
                r_histCnt  <= (r_histCnt == 2'd3) ? r_histCnt : r_histCnt + 2'd1;
                r_avgReady <= (r_histCnt == 2'd3);
                r_avgValue <= w_sum[WIDTH+1:2];
                r_avgLow   <= i_low_limit;
                r_avgHigh  <= i_high_limit;
                r_avgHyst  <= i_hyst;
            end
        end
    end

    assign w_cmpValid  = r_avgValid;
    assign w_cmpEnable = r_avgReady;
    assign w_cmpValue  = r_avgValue;
    assign w_cmpLow    = r_avgLow;
    assign w_cmpHigh   = r_avgHigh;
    assign w_cmpHyst   = r_avgHyst;
`else
    assign w_cmpValid  = i_count_valid;
    assign w_cmpEnable = 1'b1;
    assign w_cmpValue  = i_frequency_count;
    assign w_cmpLow    = i_low_limit;
    assign w_cmpHigh   = i_high_limit;
    assign w_cmpHyst   = i_hyst;
`endif

    logic                w_isLo, w_isHi, w_badCfg;
    logic [WIDTH:0]      w_lowSum;
    logic [WIDTH-1:0]    w_lowClr, w_highClr;
    logic                w_meetLowClr, w_meetHighClr;

    // Classification and clear thresholds (saturating sum, floored difference).
    always_comb begin
        w_isLo        = w_cmpValue < w_cmpLow;
        w_isHi        = w_cmpValue > w_cmpHigh;
        w_badCfg      = w_cmpLow > w_cmpHigh;
        w_lowSum      = {1'b0, w_cmpLow} + {1'b0, w_cmpHyst};
        w_lowClr      = w_lowSum[WIDTH] ? '1 : w_lowSum[WIDTH-1:0];
        w_highClr     = (w_cmpHigh >= w_cmpHyst) ? (w_cmpHigh - w_cmpHyst) : '0;
        w_meetLowClr  = w_cmpValue >= w_lowClr;
        w_meetHighClr = w_cmpValue <= w_highClr;
    end

    // Next-state logic: moves only when a compare value arrives.
    always_comb begin
        w_nextState   = r_state;
        w_nextCnt     = r_cnt;
        w_nextInRange = r_inRange;
        w_nextCfgErr  = r_cfgErr;
        if (w_cmpValid) begin
            w_nextCfgErr = w_badCfg;
            if (w_badCfg || !w_cmpEnable) begin
                w_nextState   = NORMAL;
                w_nextCnt     = '0;
                w_nextInRange = 1'b0;
            end else begin
                w_nextInRange = !w_isLo && !w_isHi;
                case (r_state)
                    NORMAL: begin
                        if (w_isLo) begin
                            w_nextState = DIRECT ? ALARM_LO : PEND_LO;
                            w_nextCnt   = DIRECT ? '0 : CW'(1);
                        end else if (w_isHi) begin
                            w_nextState = DIRECT ? ALARM_HI : PEND_HI;
                            w_nextCnt   = DIRECT ? '0 : CW'(1);
                        end
                    end
                    PEND_LO: begin
                        if (w_isLo) begin
                            if (r_cnt + CW'(1) >= CONFIRM_C) begin
                                w_nextState = ALARM_LO;
                                w_nextCnt   = '0;
                            end else begin
                                w_nextCnt = r_cnt + CW'(1);
                            end
                        end else if (w_isHi) begin
                            w_nextState = DIRECT ? ALARM_HI : PEND_HI;
                            w_nextCnt   = DIRECT ? '0 : CW'(1);
                        end else begin
                            w_nextState = NORMAL;
                            w_nextCnt   = '0;
                        end
                    end
                    PEND_HI: begin
                        if (w_isHi) begin
                            if (r_cnt + CW'(1) >= CONFIRM_C) begin
                                w_nextState = ALARM_HI;
                                w_nextCnt   = '0;
                            end else begin
                                w_nextCnt = r_cnt + CW'(1);
                            end
                        end else if (w_isLo) begin
                            w_nextState = DIRECT ? ALARM_LO : PEND_LO;
                            w_nextCnt   = DIRECT ? '0 : CW'(1);
                        end else begin
                            w_nextState = NORMAL;
                            w_nextCnt   = '0;
                        end
                    end
                    ALARM_LO: begin
                        if (w_meetLowClr) begin
                            if (w_isHi) begin
                                w_nextState = DIRECT ? ALARM_HI : PEND_HI;
                                w_nextCnt   = DIRECT ? '0 : CW'(1);
                            end else begin
                                w_nextState = NORMAL;
                                w_nextCnt   = '0;
                            end
                        end
                    end
                    ALARM_HI: begin
                        if (w_meetHighClr) begin
                            if (w_isLo) begin
                                w_nextState = DIRECT ? ALARM_LO : PEND_LO;
                                w_nextCnt   = DIRECT ? '0 : CW'(1);
                            end else begin
                                w_nextState = NORMAL;
                                w_nextCnt   = '0;
                            end
                        end
                    end
                    default: begin
                        w_nextState = NORMAL;
                        w_nextCnt   = '0;
                    end
                endcase
            end
        end
    end

    // State, confirm counter and status flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= NORMAL;
            r_cnt     <= '0;
            r_inRange <= 1'b0;
            r_cfgErr  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_inRange <= w_nextInRange;
            r_cfgErr  <= w_nextCfgErr;
        end
    end

    // Raw-sample statistics; equal values leave min/max alone, the count saturates.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_min       <= '1;
            r_max       <= '0;
            r_sampleCnt <= '0;
        end else if (w_accept) begin
            if (i_frequency_count < r_min) r_min <= i_frequency_count;
            if (i_frequency_count > r_max) r_max <= i_frequency_count;
            if (r_sampleCnt != '1) r_sampleCnt <= r_sampleCnt + SCNT_W'(1);
        end
    end

    assign o_alarm_low    = (r_state == ALARM_LO);
    assign o_alarm_high   = (r_state == ALARM_HI);
    assign o_in_range     = r_inRange;
    assign o_config_err   = r_cfgErr;
    assign o_min_count    = r_min;
    assign o_max_count    = r_max;
    assign o_sample_count = r_sampleCnt;

endmodule

// File: tb/tb_freq_limit_monitor.sv
// tb_freq_limit_monitor
// Directed, table-driven bench for freq_limit_monitor (default parameters).
// Builds with FREQ_AVG_EN defined run the averaging sequence instead.
module tb_freq_limit_monitor;

    localparam int WIDTH  = 32;
    localparam int SCNT_W = 16;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  frequencyCount;
    logic              countValid;
    logic [WIDTH-1:0]  lowLimit, highLimit, hyst;
    logic              alarmLow, alarmHigh, inRange, configErr;
    logic [WIDTH-1:0]  minCount, maxCount;
    logic [SCNT_W-1:0] sampleCount;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] freq;
        logic [31:0] low;
        logic [31:0] high;
        logic [31:0] hy;
        logic        aL;
        logic        aH;
        logic        ir;
        logic        ce;
        logic [31:0] mn;
        logic [31:0] mx;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs[$];

    freq_limit_monitor dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_frequency_count (frequencyCount),
        .i_count_valid     (countValid),
        .i_low_limit       (lowLimit),
        .i_high_limit      (highLimit),
        .i_hyst            (hyst),
        .o_alarm_low       (alarmLow),
        .o_alarm_high      (alarmHigh),
        .o_in_range        (inRange),
        .o_config_err      (configErr),
        .o_min_count       (minCount),
        .o_max_count       (maxCount),
        .o_sample_count    (sampleCount)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic valid, input logic [31:0] freq,
                                input logic [31:0] low, input logic [31:0] high, input logic [31:0] hy,
                                input logic aL, input logic aH, input logic ir, input logic ce,
                                input logic [31:0] mn, input logic [31:0] mx, input logic [15:0] sc);
        vec_t v;
        v.rst = rst; v.valid = valid; v.freq = freq; v.low = low; v.high = high; v.hy = hy;
        v.aL = aL; v.aH = aH; v.ir = ir; v.ce = ce; v.mn = mn; v.mx = mx; v.sc = sc;
        return v;
    endfunction

    task automatic checkField(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s step %0d: got %0d (0x%0h), expected %0d (0x%0h)", name, idx, act, act, exp, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset          = v.rst;
        countValid     = v.valid;
        frequencyCount = v.freq;
        lowLimit       = v.low;
        highLimit      = v.high;
        hyst           = v.hy;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        checkField("alarm_low",    idx, 32'(alarmLow),    32'(v.aL));
        checkField("alarm_high",   idx, 32'(alarmHigh),   32'(v.aH));
        checkField("in_range",     idx, 32'(inRange),     32'(v.ir));
        checkField("config_err",   idx, 32'(configErr),   32'(v.ce));
        checkField("min_count",    idx, minCount,         v.mn);
        checkField("max_count",    idx, maxCount,         v.mx);
        checkField("sample_count", idx, 32'(sampleCount), 32'(v.sc));
    endtask

    task automatic runVector(input vec_t v, input int idx);
        applyStimulus(v);
        checkOutput(v, idx);
    endtask

    initial begin
        reset          = 1'b1;
        countValid     = 1'b0;
        frequencyCount = '0;
        lowLimit       = 32'd1000;
        highLimit      = 32'd2000;
        hyst           = 32'd50;

`ifndef FREQ_AVG_EN
        //               rst vld freq   low   high  hyst aL aH ir ce min   max   cnt
        vecs.push_back(mk(1, 0,  0,     1000, 2000, 50,  0, 0, 0, 0, ONES, 0,    0));
        vecs.push_back(mk(0, 1,  1500,  1000, 2000, 50,  0, 0, 1, 0, 1500, 1500, 1));
        vecs.push_back(mk(0, 1,  1500,  1000, 2000, 50,  0, 0, 1, 0, 1500, 1500, 2));
        vecs.push_back(mk(0, 1,  900,   1000, 2000, 50,  0, 0, 0, 0, 900,  1500, 3));
        vecs.push_back(mk(0, 1,  900,   1000, 2000, 50,  0, 0, 0, 0, 900,  1500, 4));
        vecs.push_back(mk(0, 1,  900,   1000, 2000, 50,  1, 0, 0, 0, 900,  1500, 5));
        vecs.push_back(mk(0, 1,  1020,  1000, 2000, 50,  1, 0, 1, 0, 900,  1500, 6));
        vecs.push_back(mk(0, 1,  1050,  1000, 2000, 50,  0, 0, 1, 0, 900,  1500, 7));
        vecs.push_back(mk(0, 1,  2100,  1000, 2000, 50,  0, 0, 0, 0, 900,  2100, 8));
        vecs.push_back(mk(0, 1,  2100,  1000, 2000, 50,  0, 0, 0, 0, 900,  2100, 9));
        vecs.push_back(mk(0, 1,  1500,  1000, 2000, 50,  0, 0, 1, 0, 900,  2100, 10));
        vecs.push_back(mk(0, 1,  2100,  1000, 2000, 50,  0, 0, 0, 0, 900,  2100, 11));
        vecs.push_back(mk(0, 1,  2100,  1000, 2000, 50,  0, 0, 0, 0, 900,  2100, 12));
        vecs.push_back(mk(0, 1,  2100,  1000, 2000, 50,  0, 1, 0, 0, 900,  2100, 13));
        vecs.push_back(mk(0, 1,  1960,  1000, 2000, 50,  0, 1, 1, 0, 900,  2100, 14));
        vecs.push_back(mk(0, 1,  500,   1000, 2000, 50,  0, 0, 0, 0, 500,  2100, 15));
        vecs.push_back(mk(0, 1,  500,   3000, 2000, 50,  0, 0, 0, 1, 500,  2100, 16));
        vecs.push_back(mk(0, 1,  1500,  1000, 2000, 50,  0, 0, 1, 0, 500,  2100, 17));
        vecs.push_back(mk(0, 0,  7,     1000, 2000, 50,  0, 0, 1, 0, 500,  2100, 17));
        vecs.push_back(mk(0, 1,  2100,  1000, 2000, 50,  0, 0, 0, 0, 500,  2100, 18));
        vecs.push_back(mk(1, 1,  10,    1000, 2000, 50,  0, 0, 0, 0, ONES, 0,    0));
        vecs.push_back(mk(0, 1,  2100,  1000, 2000, 50,  0, 0, 0, 0, 2100, 2100, 1));
        vecs.push_back(mk(0, 1,  2100,  1000, 2000, 50,  0, 0, 0, 0, 2100, 2100, 2));
        vecs.push_back(mk(0, 1,  2100,  1000, 2000, 50,  0, 1, 0, 0, 2100, 2100, 3));
        vecs.push_back(mk(0, 1,  2000,  1000, 2000, 50,  0, 1, 1, 0, 2000, 2100, 4));
        vecs.push_back(mk(0, 1,  1950,  1000, 2000, 50,  0, 0, 1, 0, 1950, 2100, 5));
        vecs.push_back(mk(0, 1,  1000,  1000, 2000, 50,  0, 0, 1, 0, 1000, 2100, 6));

        for (int i = 0; i < vecs.size(); i++) begin
            runVector(vecs[i], i);
        end

        // Saturating low-clear threshold: with a huge hysteresis only all-ones clears the low alarm.
        runVector(mk(0, 1, 900,          1000, 2000, 32'hFFFF_FFF0, 0, 0, 0, 0, 900, 2100,          7),  100);
        runVector(mk(0, 1, 900,          1000, 2000, 32'hFFFF_FFF0, 0, 0, 0, 0, 900, 2100,          8),  101);
        runVector(mk(0, 1, 900,          1000, 2000, 32'hFFFF_FFF0, 1, 0, 0, 0, 900, 2100,          9),  102);
        runVector(mk(0, 1, 32'hFFFF_FFFE, 1000, 2000, 32'hFFFF_FFF0, 1, 0, 0, 0, 900, 32'hFFFF_FFFE, 10), 103);
        runVector(mk(0, 1, ONES,         1000, 2000, 32'hFFFF_FFF0, 0, 0, 0, 0, 900, ONES,          11), 104);
`else
        // Averaging: three suppressed samples, then averages 1100, 1200, 1300 (all HI) confirm alarm_high.
        begin
            logic [31:0] samples [0:5];
            logic        expHigh [1:8];
            samples[0] = 1000; samples[1] = 1000; samples[2] = 1000;
            samples[3] = 1400; samples[4] = 1400; samples[5] = 1400;
            for (int k = 1; k <= 8; k++) expHigh[k] = (k >= 7);
            lowLimit  = 32'd1000;
            highLimit = 32'd1050;
            hyst      = 32'd0;
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                countValid     = (k <= 6);
                frequencyCount = (k <= 6) ? samples[k-1] : 32'd0;
                @(posedge clk);
                #1;
                checkField("avg in_range",     k, 32'(inRange),     32'd0);
                checkField("avg alarm_low",    k, 32'(alarmLow),    32'd0);
                checkField("avg alarm_high",   k, 32'(alarmHigh),   32'(expHigh[k]));
                checkField("avg sample_count", k, 32'(sampleCount), (k <= 6) ? 32'(k) : 32'd6);
                @(negedge clk);
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
